// File: rtl/burst_mem_pkg.sv
// ============================================================================
// burst_mem_pkg : command encoding and decode shared by the burst memory.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package burst_mem_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'd0,
        CMD_LOAD = 3'd1,
        CMD_WR   = 3'd2,
        CMD_RD   = 3'd3,
        CMD_ERR  = 3'd4
    } cmd_e;

    // A load always wins; simultaneous write and read cancel each other.
    function automatic cmd_e decode_cmd(input logic ptr_load,
                                        input logic wr_en,
                                        input logic rd_req);
        if (ptr_load)
            return CMD_LOAD;
        else if (wr_en && rd_req)
            return CMD_ERR;
        else if (wr_en)
            return CMD_WR;
        else if (rd_req)
            return CMD_RD;
        else
            return CMD_IDLE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/burst_ptr.sv
// ============================================================================
// burst_ptr : auto-incrementing address pointer with wrap or saturate and a
//             sticky overflow flag cleared only by load or reset.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_ptr #(
    parameter int ADDR_WIDTH = 7,
    parameter bit WRAP_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  ovf
);

    localparam logic [ADDR_WIDTH-1:0] C_PTR_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            ptr <= load_addr;
            ovf <= 1'b0;
        end else if (advance) begin
            if (ptr == C_PTR_MAX) begin
                ovf <= 1'b1;
                // In saturate mode the pointer parks at max so further
                // accesses keep hitting the last word.
                if (WRAP_EN)
                    ptr <= '0;
            end else begin
                ptr <= ptr + C_PTR_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/burst_mem.sv
// ============================================================================
// burst_mem : single-port memory with auto-incrementing pointer, separate
//             write/read paths and a registered read with valid strobe.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module burst_mem
    import burst_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter bit WRAP_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ptr_load,
    input  logic [ADDR_WIDTH-1:0] ptr_addr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] ptr,
    output logic                  ovf,
    output logic                  err
);

    localparam int C_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_word;
    logic                  r_rd_pend;
    cmd_e                  w_cmd;
    logic                  w_advance;
    logic                  w_err;

    assign w_cmd     = decode_cmd(ptr_load, wr_en, rd_req);
    assign w_advance = (w_cmd == CMD_WR) || (w_cmd == CMD_RD);
    assign w_err     = (w_cmd == CMD_ERR) || (ptr_load && (wr_en || rd_req));

    burst_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WRAP_EN    (WRAP_EN)
    ) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .load      (w_cmd == CMD_LOAD),
        .load_addr (ptr_addr),
        .advance   (w_advance),
        .ptr       (ptr),
        .ovf       (ovf)
    );

    // Storage carries no reset; only the write strobe is gated by rst.
    always_ff @(posedge clk) begin
        if (!rst && (w_cmd == CMD_WR))
            r_mem[ptr] <= wr_data;
    end

    // Read is captured into a pending stage, then presented one edge later,
    // so a reset on the following edge squashes the strobe entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_word <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            err       <= 1'b0;
        end else begin
            r_rd_pend <= (w_cmd == CMD_RD);
            if (w_cmd == CMD_RD)
                r_rd_word <= r_mem[ptr];
            rd_valid <= r_rd_pend;
            if (r_rd_pend)
                rd_data <= r_rd_word;
            err <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_burst_mem.sv
// ============================================================================
// tb_burst_mem : directed bench driving a wrapping and a saturating instance
//                with identical stimulus (index 0 = wrap, 1 = saturate).
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_burst_mem;

    logic            clk = 1'b0;
    logic            rst;
    logic            ptr_load;
    logic [6:0]      ptr_addr;
    logic            wr_en;
    logic [7:0]      wr_data;
    logic            rd_req;
    logic [1:0][7:0] rdd;
    logic [1:0][6:0] ptrv;
    logic [1:0]      rv;
    logic [1:0]      ov;
    logic [1:0]      er;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    burst_mem #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .WRAP_EN(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .ptr_load(ptr_load), .ptr_addr(ptr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
        .rd_data(rdd[0]), .rd_valid(rv[0]), .ptr(ptrv[0]), .ovf(ov[0]), .err(er[0])
    );

    burst_mem #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .WRAP_EN(1'b0)) dut_sat (
        .clk(clk), .rst(rst), .ptr_load(ptr_load), .ptr_addr(ptr_addr),
        .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req),
        .rd_data(rdd[1]), .rd_valid(rv[1]), .ptr(ptrv[1]), .ovf(ov[1]), .err(er[1])
    );

    // Apply one cycle of inputs, consume one rising edge, settle 1 time unit.
    task automatic cyc(input logic r, input logic l, input logic [6:0] a,
                       input logic w, input logic [7:0] d, input logic q);
        rst = r; ptr_load = l; ptr_addr = a; wr_en = w; wr_data = d; rd_req = q;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1, 0, 7'h00, 0, 8'h00, 0);
        cyc(1, 0, 7'h00, 0, 8'h00, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 5;
            if (ptrv[k] !== 7'h00) begin failures++; $display("FAIL reset_ptr[%0d] got=%h exp=00", k, ptrv[k]); end
            if (rv[k] !== 1'b0)    begin failures++; $display("FAIL reset_rd_valid[%0d] got=%b exp=0", k, rv[k]); end
            if (ov[k] !== 1'b0)    begin failures++; $display("FAIL reset_ovf[%0d] got=%b exp=0", k, ov[k]); end
            if (er[k] !== 1'b0)    begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", k, er[k]); end
            if (rdd[k] !== 8'h00)  begin failures++; $display("FAIL reset_rd_data[%0d] got=%h exp=00", k, rdd[k]); end
        end
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
    endtask

    task automatic test_burst;
        logic       exp_v [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] exp_d [5] = '{8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hC3};
        logic       rd_vec[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        cyc(0, 1, 7'h10, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 1, 8'hA1, 0);
        cyc(0, 0, 7'h00, 1, 8'hB2, 0);
        cyc(0, 0, 7'h00, 1, 8'hC3, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ptrv[k] !== 7'h13) begin failures++; $display("FAIL burst_wr_ptr[%0d] got=%h exp=13", k, ptrv[k]); end
        end
        cyc(0, 1, 7'h10, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 7'h00, 0, 8'h00, rd_vec[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] !== exp_v[i]) begin failures++; $display("FAIL burst_rd_valid[%0d] step=%0d got=%b exp=%b", k, i, rv[k], exp_v[i]); end
                if (i > 0) begin
                    checks++;
                    if (rdd[k] !== exp_d[i]) begin failures++; $display("FAIL burst_rd_data[%0d] step=%0d got=%h exp=%h", k, i, rdd[k], exp_d[i]); end
                end
            end
            if (i == 2) begin
                checks++;
                if (ptrv[0] !== 7'h13) begin failures++; $display("FAIL burst_rd_ptr got=%h exp=13", ptrv[0]); end
            end
        end
    endtask

    task automatic test_wrap;
        cyc(0, 1, 7'h7F, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 1, 8'h55, 0);
        cyc(0, 0, 7'h00, 1, 8'h66, 0);
        checks += 4;
        if (ptrv[0] !== 7'h01) begin failures++; $display("FAIL wrap_ptr got=%h exp=01", ptrv[0]); end
        if (ov[0] !== 1'b1)    begin failures++; $display("FAIL wrap_ovf got=%b exp=1", ov[0]); end
        if (ptrv[1] !== 7'h7F) begin failures++; $display("FAIL sat_ptr_a got=%h exp=7f", ptrv[1]); end
        if (ov[1] !== 1'b1)    begin failures++; $display("FAIL sat_ovf_a got=%b exp=1", ov[1]); end
        // Read back: wrap sees 0x55 then mem[0]=0x66; saturate sees 0x66 twice.
        cyc(0, 1, 7'h7F, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 0, 8'h00, 1);
        cyc(0, 0, 7'h00, 0, 8'h00, 1);
        checks += 2;
        if (rv[0] !== 1'b1 || rdd[0] !== 8'h55) begin failures++; $display("FAIL wrap_rd_7f got=%b/%h exp=1/55", rv[0], rdd[0]); end
        if (rv[1] !== 1'b1 || rdd[1] !== 8'h66) begin failures++; $display("FAIL sat_rd_7f_a got=%b/%h exp=1/66", rv[1], rdd[1]); end
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
        checks += 2;
        if (rv[0] !== 1'b1 || rdd[0] !== 8'h66) begin failures++; $display("FAIL wrap_rd_00 got=%b/%h exp=1/66", rv[0], rdd[0]); end
        if (rv[1] !== 1'b1 || rdd[1] !== 8'h66) begin failures++; $display("FAIL sat_rd_7f_b got=%b/%h exp=1/66", rv[1], rdd[1]); end
        cyc(0, 1, 7'h00, 0, 8'h00, 0);
        checks += 2;
        if (ov[0] !== 1'b0) begin failures++; $display("FAIL wrap_ovf_clear got=%b exp=0", ov[0]); end
        if (ov[1] !== 1'b0) begin failures++; $display("FAIL sat_ovf_clear got=%b exp=0", ov[1]); end
    endtask

    task automatic test_saturate;
        cyc(0, 1, 7'h7F, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 1, 8'h11, 0);
        cyc(0, 0, 7'h00, 1, 8'h22, 0);
        checks += 2;
        if (ptrv[1] !== 7'h7F) begin failures++; $display("FAIL sat_ptr_b got=%h exp=7f", ptrv[1]); end
        if (ov[1] !== 1'b1)    begin failures++; $display("FAIL sat_ovf_b got=%b exp=1", ov[1]); end
        // Read immediately after the write, same address.
        cyc(0, 0, 7'h00, 0, 8'h00, 1);
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
        checks++;
        if (rv[1] !== 1'b1 || rdd[1] !== 8'h22) begin failures++; $display("FAIL sat_wr_then_rd got=%b/%h exp=1/22", rv[1], rdd[1]); end
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
    endtask

    task automatic test_illegal;
        cyc(0, 1, 7'h05, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 1, 8'h77, 0);
        cyc(0, 1, 7'h05, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 1, 8'hEE, 1);
        checks += 3;
        if (ptrv[0] !== 7'h05) begin failures++; $display("FAIL wr_rd_ptr got=%h exp=05", ptrv[0]); end
        if (er[0] !== 1'b1)    begin failures++; $display("FAIL wr_rd_err got=%b exp=1", er[0]); end
        if (rv[0] !== 1'b0)    begin failures++; $display("FAIL wr_rd_valid got=%b exp=0", rv[0]); end
        cyc(0, 0, 7'h00, 0, 8'h00, 1);
        checks += 2;
        if (er[0] !== 1'b0) begin failures++; $display("FAIL wr_rd_err_pulse got=%b exp=0", er[0]); end
        if (rv[0] !== 1'b0) begin failures++; $display("FAIL wr_rd_no_valid got=%b exp=0", rv[0]); end
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
        checks++;
        if (rv[0] !== 1'b1 || rdd[0] !== 8'h77) begin failures++; $display("FAIL wr_rd_no_write got=%b/%h exp=1/77", rv[0], rdd[0]); end

        cyc(0, 1, 7'h20, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 1, 8'h44, 0);
        cyc(0, 1, 7'h20, 1, 8'h99, 0);
        checks += 2;
        if (ptrv[0] !== 7'h20) begin failures++; $display("FAIL load_wr_ptr got=%h exp=20", ptrv[0]); end
        if (er[0] !== 1'b1)    begin failures++; $display("FAIL load_wr_err got=%b exp=1", er[0]); end
        cyc(0, 0, 7'h00, 0, 8'h00, 1);
        checks++;
        if (er[0] !== 1'b0) begin failures++; $display("FAIL load_wr_err_pulse got=%b exp=0", er[0]); end
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
        checks += 2;
        if (rv[0] !== 1'b1 || rdd[0] !== 8'h44) begin failures++; $display("FAIL load_wr_no_write got=%b/%h exp=1/44", rv[0], rdd[0]); end
        if (ptrv[0] !== 7'h21) begin failures++; $display("FAIL load_wr_rd_ptr got=%h exp=21", ptrv[0]); end
    endtask

    task automatic test_reset_mid_read;
        cyc(0, 1, 7'h10, 0, 8'h00, 0);
        cyc(0, 0, 7'h00, 0, 8'h00, 1);
        cyc(1, 0, 7'h00, 0, 8'h00, 0);
        for (int k = 0; k < 2; k++) begin
            checks += 3;
            if (rv[k] !== 1'b0)    begin failures++; $display("FAIL rst_mid_valid[%0d] got=%b exp=0", k, rv[k]); end
            if (ptrv[k] !== 7'h00) begin failures++; $display("FAIL rst_mid_ptr[%0d] got=%h exp=00", k, ptrv[k]); end
            if (rdd[k] !== 8'h00)  begin failures++; $display("FAIL rst_mid_data[%0d] got=%h exp=00", k, rdd[k]); end
        end
        cyc(0, 0, 7'h00, 0, 8'h00, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv[k] !== 1'b0) begin failures++; $display("FAIL rst_mid_valid_after[%0d] got=%b exp=0", k, rv[k]); end
        end
    endtask

    initial begin
        rst = 1'b1; ptr_load = 1'b0; ptr_addr = '0;
        wr_en = 1'b0; wr_data = '0; rd_req = 1'b0;
        test_reset;
        test_burst;
        test_wrap;
        test_saturate;
        test_illegal;
        test_reset_mid_read;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/burst_mem.md
Name: burst_mem

Overview:
Parametrised single-port memory with an internal auto-incrementing address pointer, intended as the register/storage backend behind the I2C slave. The slave loads the pointer once, then streams sequential byte writes or reads without re-addressing. It replaces the tri-state data bus with separate write/read paths and a registered read with a valid strobe. Pointer overflow is either wrapped or saturated, selected by parameter.

Parameters:
ADDR_WIDTH, 7, pointer/address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, word width
WRAP_EN, 1, 1 = pointer wraps max->0; 0 = pointer saturates at max

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ptr_load  in  1  load pointer from ptr_addr this cycle
ptr_addr  in  ADDR_WIDTH  pointer load value
wr_en  in  1  write wr_data to mem[ptr], then advance ptr
wr_data  in  DATA_WIDTH  write data
rd_req  in  1  read mem[ptr], then advance ptr
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  one-cycle strobe, rd_data valid
ptr  out  ADDR_WIDTH  current pointer value
ovf  out  1  sticky overflow flag
err  out  1  one-cycle strobe, illegal command combination

Behaviour:
- Reset, synchronous to clk with rst high: ptr=0, rd_data=0, rd_valid=0, ovf=0, err=0. Memory contents are not reset and are undefined until written. Reset overrides every input in the same cycle, and a read issued in the cycle before reset produces no rd_valid.
- Command decode per cycle, mutually exclusive:
  - LOAD (ptr_load only): ptr <= ptr_addr; ovf <= 0.
  - WR (wr_en only): mem[ptr] <= wr_data; ptr advances.
  - RD (rd_req only): rd_data <= mem[ptr]; rd_valid <= 1 next cycle; ptr advances.
  - IDLE (none asserted): no change; rd_valid <= 0.
- Illegal combinations:
  - ptr_load together with wr_en and/or rd_req: the load executes, the access is dropped, err=1 next cycle.
  - wr_en together with rd_req, no load: both dropped, ptr unchanged, err=1 next cycle.
- Read latency is 1: a request at edge N gives rd_valid/rd_data after edge N+1. rd_data holds its last value while rd_valid=0.
- Write-then-read: a write at edge N to address A, followed by a read of A at edge N+1, returns the new data. Back-to-back reads at one per cycle are supported, with rd_valid continuously high.
- Pointer advance at ptr = 2**ADDR_WIDTH-1:
  - WRAP_EN=1: ptr -> 0 and ovf <= 1.
  - WRAP_EN=0: ptr stays at max, the access is still performed at max, and ovf <= 1.
  - ovf stays set until the next LOAD or rst.
- Below max, ptr advances by +1 modulo 2**ADDR_WIDTH.
- err and rd_valid are registered pulses, never combinational from inputs.

Decomposition:
- Package burst_mem_pkg holds:
  - enum cmd_e {CMD_IDLE, CMD_LOAD, CMD_WR, CMD_RD, CMD_ERR};
  - function decode_cmd(ptr_load, wr_en, rd_req) returning cmd_e.
- One sub-module, burst_ptr: the pointer register with load, advance, wrap/saturate (WRAP_EN) and sticky ovf. The top level holds the memory array, decode and read register.

Test Plan:
- Reset then idle: rst high 2 cycles -> ptr=0, rd_valid=0, ovf=0, err=0. Check both WRAP_EN values.
- Burst write/read: LOAD 0x10; WR 0xA1, 0xB2, 0xC3 on consecutive cycles -> ptr=0x13. LOAD 0x10; 3 consecutive RD -> rd_valid high 3 cycles with 0xA1, 0xB2, 0xC3, ptr=0x13.
- Wrap (WRAP_EN=1): LOAD 0x7F; WR 0x55, WR 0x66 -> mem[0x7F]=0x55, mem[0x00]=0x66, ptr=0x01, ovf=1. LOAD 0x00 -> ovf=0.
- Saturate (WRAP_EN=0): LOAD 0x7F; WR 0x11, WR 0x22 -> mem[0x7F]=0x22, ptr=0x7F, ovf=1.
- Illegal commands:
  - wr_en+rd_req at ptr=0x05 -> no write, ptr=0x05, err pulse 1 cycle, rd_valid=0.
  - ptr_load=0x20 with wr_en -> ptr=0x20, no write, err pulse.
- Reset mid-read: RD at edge N, rst at edge N+1 -> rd_valid stays 0 and ptr=0 after N+1.
